// File: rtl/flash_port_if.sv
// Bundles the two requester ports and the Wishbone read port of the flash arbiter.
// master is the arbiter's view; slave is the view of the requesters plus flash reader.
interface flash_port_if #(
  parameter int AW = 22
);
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_ack;
  logic          m0_err;
  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic          m1_ack;
  logic          m1_err;
  logic [31:0]   rdata;
  logic          busy;
  logic          wb_cyc;
  logic          wb_stb;
  logic [AW-1:0] wb_addr;
  logic [3:0]    wb_sel;
  logic          wb_stall;
  logic          wb_ack;
  logic [31:0]   wb_data;

  modport master (
    input  m0_req, m0_addr, m1_req, m1_addr, wb_stall, wb_ack, wb_data,
    output m0_ack, m0_err, m1_ack, m1_err, rdata, busy,
           wb_cyc, wb_stb, wb_addr, wb_sel
  );

  modport slave (
    output m0_req, m0_addr, m1_req, m1_addr, wb_stall, wb_ack, wb_data,
    input  m0_ack, m0_err, m1_ack, m1_err, rdata, busy,
           wb_cyc, wb_stb, wb_addr, wb_sel
  );
endinterface

// File: rtl/flash_port_arbiter.sv
// Round-robin arbiter sharing the SPI flash reader's Wishbone read port between the
// 68040 front-end (port 0) and the boot copier (port 1), with page relocation and a watchdog.
module flash_port_arbiter #(
  parameter int       AW         = 22,
  parameter bit [7:0] FLASH_PAGE = 8'h04,
  parameter int       TW         = 10,
  parameter int       TIMEOUT    = 1000
) (
  input logic         clk,
  input logic         rst,
  flash_port_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic          gnt, gnt_nx;
  logic          last, last_nx;
  logic [AW-1:0] addr_q, addr_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic [31:0]   rdata_q, rdata_nx;
  logic [1:0]    err_q, err_nx;

  // Page field is the top 8 address bits; the add wraps modulo 256.
  function automatic logic [AW-1:0] relocate(input logic [AW-1:0] a);
    logic [7:0] page;
    page = a[AW-1 -: 8] + FLASH_PAGE;
    return {page, a[AW-9:0]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      last    <= 1'b1;
      addr_q  <= '0;
      tmo     <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      last    <= last_nx;
      addr_q  <= addr_nx;
      tmo     <= tmo_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    addr_nx  = addr_q;
    tmo_nx   = tmo;
    rdata_nx = rdata_q;
    err_nx   = 2'b00;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          if (bus.m0_req && bus.m1_req) gnt_nx = ~last;
          else                          gnt_nx = bus.m1_req;
          last_nx  = gnt_nx;
          addr_nx  = relocate(gnt_nx ? bus.m1_addr : bus.m0_addr);
          tmo_nx   = '0;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        tmo_nx = tmo + TW'(1);
        // An ack that arrives with acceptance completes the read; it also beats the watchdog.
        if (!bus.wb_stall && bus.wb_ack) begin
          rdata_nx = bus.wb_data;
          state_nx = DONE;
        end else if (tmo == TMO_LAST) begin
          err_nx   = gnt ? 2'b10 : 2'b01;
          state_nx = IDLE;
        end else if (!bus.wb_stall) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        tmo_nx = tmo + TW'(1);
        if (bus.wb_ack) begin
          rdata_nx = bus.wb_data;
          state_nx = DONE;
        end else if (tmo == TMO_LAST) begin
          err_nx   = gnt ? 2'b10 : 2'b01;
          state_nx = IDLE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.wb_cyc  = (state == ISSUE) || (state == WAIT);
  assign bus.wb_stb  = (state == ISSUE);
  assign bus.wb_sel  = bus.wb_cyc ? 4'hF : 4'h0;
  assign bus.wb_addr = addr_q;
  assign bus.busy    = (state != IDLE);
  assign bus.rdata   = rdata_q;
  assign bus.m0_ack  = (state == DONE) && !gnt;
  assign bus.m1_ack  = (state == DONE) && gnt;
  assign bus.m0_err  = err_q[0];
  assign bus.m1_err  = err_q[1];

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed bench for flash_port_arbiter: a flash-reader model answers each Wishbone read,
// and a scoreboard of expected port/data responses is checked as acks and errs appear.
module tb_flash_port_arbiter;
  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  flash_port_if #(.AW(AW)) bus ();

  flash_port_arbiter #(
    .AW(AW), .FLASH_PAGE(8'h04), .TW(10), .TIMEOUT(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          port;
    logic          err;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] last_rd = '0;

  function automatic logic [AW-1:0] reloc(input logic [AW-1:0] a);
    logic [7:0] hi;
    hi = a[21:14] + 8'h04;
    return {hi, a[13:0]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == 22'h010010) return 32'h4E714E71;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic p, input logic [AW-1:0] a, input logic hang);
    exp_t e;
    e.port = p;
    e.err  = hang;
    e.addr = reloc(a);
    e.data = mem_word(reloc(a));
    if (p) begin bus.m1_req = 1'b1; bus.m1_addr = a; end
    else   begin bus.m0_req = 1'b1; bus.m0_addr = a; end
    sb.push_back(e);
  endtask

  // Plays the flash reader for the transaction at the head of the scoreboard, then checks
  // the response pulse and the return to IDLE.
  task automatic serve(input string tag, input int stall_n, input int lat, input int exp_wait);
    exp_t          e;
    int            t;
    int            c;
    int            hi;
    logic          addr_ok;
    logic          done;
    logic [AW-1:0] a;
    e = sb[0];
    t = 0;
    while (bus.wb_stb !== 1'b1 && t < 50) begin tick(); t++; end
    if (exp_wait >= 0) chk({tag, " req_to_stb"}, t, exp_wait);
    chk({tag, " wb_addr"}, bus.wb_addr, e.addr);
    chk({tag, " wb_sel"}, bus.wb_sel, 4'hF);
    a = bus.wb_addr;
    hi = 0; addr_ok = 1'b1; done = 1'b0; c = 0;
    while (!done && c < 1100) begin
      if (bus.wb_stb === 1'b1) hi++;
      if (bus.wb_addr !== a) addr_ok = 1'b0;
      bus.wb_stall = (c < stall_n);
      bus.wb_ack   = !e.err && (c == stall_n + lat);
      bus.wb_data  = bus.wb_ack ? mem_word(bus.wb_addr) : 32'hDEADBEEF;
      tick();
      c++;
      bus.wb_stall = 1'b0;
      bus.wb_ack   = 1'b0;
      bus.wb_data  = 32'hDEADBEEF;
      done = bus.m0_ack | bus.m1_ack | bus.m0_err | bus.m1_err;
    end
    chk({tag, " resp_cycle"}, c, e.err ? 1000 : stall_n + lat + 1);
    chk({tag, " stb_cycles"}, hi, stall_n + 1);
    chk({tag, " addr_stable"}, addr_ok, 1'b1);
    chk({tag, " cyc_low"}, {bus.wb_cyc, bus.wb_stb, bus.wb_sel}, 6'b0);
    e = sb.pop_front();
    chk({tag, " m0_ack"}, bus.m0_ack, !e.err && !e.port);
    chk({tag, " m1_ack"}, bus.m1_ack, !e.err && e.port);
    chk({tag, " m0_err"}, bus.m0_err, e.err && !e.port);
    chk({tag, " m1_err"}, bus.m1_err, e.err && e.port);
    chk({tag, " rdata"}, bus.rdata, e.err ? last_rd : e.data);
    if (!e.err) last_rd = e.data;
    if (e.port) bus.m1_req = 1'b0;
    else        bus.m0_req = 1'b0;
    tick();
    chk({tag, " pulse_len"}, {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}, 4'b0);
    chk({tag, " busy_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.m0_req = 1'b0; bus.m0_addr = '0;
    bus.m1_req = 1'b0; bus.m1_addr = '0;
    bus.wb_stall = 1'b0; bus.wb_ack = 1'b0; bus.wb_data = 32'hDEADBEEF;
    #1;
    chk("reset outputs",
        {bus.wb_cyc, bus.wb_stb, bus.wb_sel, bus.busy, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err},
        11'b0);
    chk("reset rdata", bus.rdata, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // T2: simultaneous requests alternate starting with port 0
    raise(1'b0, 22'h000100, 1'b0);
    raise(1'b1, 22'h200200, 1'b0);
    serve("T2a", 0, 3, 1);
    serve("T2b", 0, 0, 1);
    raise(1'b0, 22'h000300, 1'b0);
    raise(1'b1, 22'h3F0400, 1'b0);
    serve("T2c", 0, 2, 1);
    serve("T2d", 2, 1, 1);

    // T1: plain port 0 read with a slow reader
    raise(1'b0, 22'h000010, 1'b0);
    serve("T1", 0, 40, 1);
    chk("T1 wb_addr_const", bus.wb_addr, 22'h010010);
    chk("T1 rdata_const", bus.rdata, 32'h4E714E71);

    // T3: stalled strobe
    raise(1'b1, 22'h0A5555, 1'b0);
    serve("T3", 5, 4, 1);

    // T6: page add wraps
    raise(1'b0, {8'hFE, 14'h0123}, 1'b0);
    serve("T6", 0, 1, 1);
    chk("T6 page_wrap", bus.wb_addr[21:14], 8'h02);

    // T4: reader never answers port 1
    raise(1'b1, 22'h123456, 1'b1);
    serve("T4", 0, 0, 1);

    // T5: reset in the middle of a read; last port served before reset is port 0
    raise(1'b0, 22'h001234, 1'b0);
    t = 0;
    while (bus.wb_stb !== 1'b1 && t < 50) begin tick(); t++; end
    tick(); tick();
    chk("T5 busy_in_wait", {bus.busy, bus.wb_cyc, bus.wb_stb}, 3'b110);
    #2 rst = 1'b0;
    #1;
    chk("T5 async_outputs",
        {bus.wb_cyc, bus.wb_stb, bus.wb_sel, bus.busy, bus.m0_ack, bus.m1_ack},
        9'b0);
    chk("T5 async_rdata", bus.rdata, 32'h0);
    bus.m0_req = 1'b0;
    sb.delete();
    last_rd = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    raise(1'b0, 22'h000777, 1'b0);
    raise(1'b1, 22'h000888, 1'b0);
    serve("T5a", 0, 2, 1);
    serve("T5b", 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
